// File: rtl/lsu_mstage.sv
// lsu_mstage: memory-stage load/store unit.
// Accepts one memory op at a time from the execute stage, drives a
// req/gnt/rvalid data-memory port, and returns aligned, sign/zero-extended
// load data as a one-cycle register-file writeback.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   x_valid/x_load/x_funct3/x_addr/x_wdata/x_rd   op from execute stage
//   ready               idle and able to accept (low stalls the issuer)
//   misalign            one-cycle pulse when an op is rejected
//   dmem_req/we/be/addr/wdata   memory request, held until dmem_gnt
//   dmem_gnt/rvalid/rdata       memory handshake and read data
//   wb_v/wb_rd/wb_data  register writeback, wb_v is a one-cycle pulse
module lsu_mstage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            x_valid,
  input  logic            x_load,
  input  logic [2:0]      x_funct3,
  input  logic [XLEN-1:0] x_addr,
  input  logic [XLEN-1:0] x_wdata,
  input  logic [4:0]      x_rd,
  output logic            ready,
  output logic            misalign,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_v,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_nx;
  logic            accept, illegal, unaligned, go, reject;
  logic [3:0]      be_nx;
  logic [XLEN-1:0] wdata_nx;
  logic [XLEN-1:0] shifted, load_ext;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;
  logic            wb_fire;

  assign ready    = (state == IDLE);
  // Request is decoded from state so an asynchronous reset removes it at once.
  assign dmem_req = (state == REQ);

  always_comb begin
    accept    = x_valid & ready;
    illegal   = (x_funct3 == 3'b011) | (x_funct3[2:1] == 2'b11) |
                (~x_load & x_funct3[2]);
    unaligned = ((x_funct3[1:0] == 2'b01) & x_addr[0]) |
                ((x_funct3[1:0] == 2'b10) & (x_addr[1:0] != 2'b00));
    go        = accept & ~illegal & ~unaligned;
    reject    = accept & (illegal | unaligned);
  end

  // Loads always read the full word; lane selection happens on return.
  always_comb begin
    be_nx    = 4'b1111;
    wdata_nx = x_wdata;
    if (!x_load) begin
      unique case (x_funct3[1:0])
        2'b00: begin
          be_nx    = 4'b0001 << x_addr[1:0];
          wdata_nx = {4{x_wdata[7:0]}};
        end
        2'b01: begin
          be_nx    = 4'b0011 << x_addr[1:0];
          wdata_nx = {2{x_wdata[15:0]}};
        end
        default: begin
          be_nx    = 4'b1111;
          wdata_nx = x_wdata;
        end
      endcase
    end
  end

  always_comb begin
    shifted  = dmem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    unique case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'b0, shifted[7:0]};
      3'b101:  load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = REQ;
      REQ:     if (dmem_gnt) state_nx = dmem_we ? IDLE : WAIT;
      WAIT:    if (dmem_rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign wb_fire = (state == WAIT) & dmem_rvalid & (rd_q != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      wb_v       <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      misalign <= reject;
      wb_v     <= wb_fire;
      if (go) begin
        dmem_we    <= ~x_load;
        dmem_be    <= be_nx;
        dmem_addr  <= {x_addr[XLEN-1:2], 2'b00};
        dmem_wdata <= wdata_nx;
        f3_q       <= x_funct3;
        off_q      <= x_addr[1:0];
        rd_q       <= x_rd;
      end
      // rd = 0 loads leave the writeback registers untouched.
      if (wb_fire) begin
        wb_rd   <= rd_q;
        wb_data <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mstage.sv
module tb_lsu_mstage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_valid, x_load;
  logic [2:0]  x_funct3;
  logic [31:0] x_addr, x_wdata;
  logic [4:0]  x_rd;
  logic        ready, misalign, dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_v;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic        exp_we;
  logic        mis_allowed = 1'b0;
  logic [36:0] wb_q[$];

  lsu_mstage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .x_valid(x_valid), .x_load(x_load), .x_funct3(x_funct3),
    .x_addr(x_addr), .x_wdata(x_wdata), .x_rd(x_rd),
    .ready(ready), .misalign(misalign),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_v(wb_v), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the architectural rules.
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
    longint v;
    logic [31:0] s;
    s = rdata >> (8 * (a % 4));
    case (f3)
      3'b000: begin v = s % 256;   if (v >= 128)   v -= 256;   end
      3'b001: begin v = s % 65536; if (v >= 32768) v -= 65536; end
      3'b100: v = s % 256;
      3'b101: v = s % 65536;
      default: v = s;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_be(input logic ld, input logic [2:0] f3, input logic [31:0] a);
    if (ld) return 4'hF;
    case (f3)
      3'b000:  return 4'(1 << (a % 4));
      3'b001:  return 4'(3 << (a % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return (w % 256) * 32'h0101_0101;
      3'b001:  return (w % 65536) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  // Compare process: request fields and writebacks against the model.
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (dmem_req) begin
        chk("req_addr",  dmem_addr,  exp_addr);
        chk("req_be",    {28'd0, dmem_be}, {28'd0, exp_be});
        chk("req_we",    {31'd0, dmem_we}, {31'd0, exp_we});
        if (exp_we) chk("req_wdata", dmem_wdata, exp_wdata);
      end
      if (wb_v) begin
        if (wb_q.size() == 0) chk("wb_unexpected", {31'd0, wb_v}, 32'd0);
        else begin
          logic [36:0] e;
          e = wb_q.pop_front();
          chk("wb_rd",   {27'd0, wb_rd}, {27'd0, e[36:32]});
          chk("wb_data", wb_data, e[31:0]);
        end
      end
      if (misalign && !mis_allowed) chk("misalign_spurious", {31'd0, misalign}, 32'd0);
    end
  end

  // Present an op (call at a negedge); sets model expectations.
  task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] w, input logic [4:0] rd, input logic [31:0] rdata);
    chk("ready_at_issue", {31'd0, ready}, 32'd1);
    exp_addr  = a & 32'hFFFF_FFFC;
    exp_be    = m_be(ld, f3, a);
    exp_we    = !ld;
    exp_wdata = m_wdata(f3, w);
    if (ld && rd != 0) wb_q.push_back({rd, m_load(f3, a, rdata)});
    x_load = ld; x_funct3 = f3; x_addr = a; x_wdata = w; x_rd = rd;
    x_valid = 1'b1;
  endtask

  // Memory side, entered at the negedge after acceptance.
  task automatic serve(input logic ld, input int gd, input int rvd, input logic [31:0] rdata);
    for (int i = 0; i < gd; i++) begin
      chk("req_held",   {31'd0, dmem_req}, 32'd1);
      chk("ready_busy", {31'd0, ready},    32'd0);
      @(negedge clk);
    end
    chk("req_at_gnt", {31'd0, dmem_req}, 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    if (!ld) begin
      chk("ready_after_store", {31'd0, ready}, 32'd1);
      chk("store_no_wb",       {31'd0, wb_v},  32'd0);
      return;
    end
    chk("ready_wait", {31'd0, ready},    32'd0);
    chk("req_wait",   {31'd0, dmem_req}, 32'd0);
    for (int i = 0; i < rvd; i++) begin
      @(negedge clk);
      chk("ready_wait", {31'd0, ready}, 32'd0);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h5A5A_A5A5;
    chk("ready_after_load", {31'd0, ready}, 32'd1);
  endtask

  task automatic simple(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] w, input logic [4:0] rd, input logic [31:0] rdata,
                        input int gd, input int rvd);
    @(negedge clk);
    issue(ld, f3, a, w, rd, rdata);
    @(negedge clk);
    x_valid = 1'b0;
    serve(ld, gd, rvd, rdata);
  endtask

  task automatic reject_op(input logic ld, input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    mis_allowed = 1'b1;
    x_load = ld; x_funct3 = f3; x_addr = a; x_wdata = 32'h0; x_rd = 5'd9;
    x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    chk("misalign_pulse", {31'd0, misalign}, 32'd1);
    chk("misalign_noreq", {31'd0, dmem_req}, 32'd0);
    chk("misalign_ready", {31'd0, ready},    32'd1);
    @(negedge clk);
    chk("misalign_end",   {31'd0, misalign}, 32'd0);
    chk("misalign_noreq", {31'd0, dmem_req}, 32'd0);
    mis_allowed = 1'b0;
    @(negedge clk);
    chk("misalign_nowb",  {31'd0, wb_v},     32'd0);
  endtask

  initial begin
    rst_n = 1'b0; x_valid = 1'b0; x_load = 1'b0; x_funct3 = '0;
    x_addr = '0; x_wdata = '0; x_rd = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    exp_addr = '0; exp_be = '0; exp_we = 1'b0; exp_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready",    {31'd0, ready},    32'd1);
    chk("rst_req",      {31'd0, dmem_req}, 32'd0);
    chk("rst_we",       {31'd0, dmem_we},  32'd0);
    chk("rst_be",       {28'd0, dmem_be},  32'd0);
    chk("rst_addr",     dmem_addr,         32'd0);
    chk("rst_wdata",    dmem_wdata,        32'd0);
    chk("rst_wbv",      {31'd0, wb_v},     32'd0);
    chk("rst_wbdata",   wb_data,           32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    rst_n = 1'b1;

    // LB at 0x103, literal pins on request and result.
    @(negedge clk);
    issue(1'b1, 3'b000, 32'h103, 32'h0, 5'd5, 32'h80FF_1234);
    @(negedge clk);
    x_valid = 1'b0;
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_be",   {28'd0, dmem_be}, 32'hF);
    chk("lb_we",   {31'd0, dmem_we}, 32'd0);
    serve(1'b1, 0, 0, 32'h80FF_1234);
    chk("lb_wbv",  {31'd0, wb_v}, 32'd1);
    chk("lb_rd",   {27'd0, wb_rd}, 32'd5);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    @(negedge clk);
    chk("wb_pulse_one", {31'd0, wb_v}, 32'd0);
    chk("wb_hold",      wb_data, 32'hFFFF_FF80);

    // LBU same stimulus.
    simple(1'b1, 3'b100, 32'h103, 32'h0, 5'd5, 32'h80FF_1234, 0, 0);
    chk("lbu_data", wb_data, 32'h0000_0080);

    // SH with gnt delayed 3 cycles.
    @(negedge clk);
    issue(1'b0, 3'b001, 32'h202, 32'hDEAD_BEEF, 5'd0, 32'h0);
    @(negedge clk);
    x_valid = 1'b0;
    chk("sh_be",    {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    chk("sh_we",    {31'd0, dmem_we}, 32'd1);
    serve(1'b0, 3, 0, 32'h0);

    // Further lanes and widths.
    simple(1'b1, 3'b001, 32'h602, 32'h0, 5'd6,  32'h8001_7FFF, 1, 2);
    chk("lh_data", wb_data, 32'hFFFF_8001);
    simple(1'b1, 3'b101, 32'h602, 32'h0, 5'd7,  32'h8001_7FFF, 0, 1);
    simple(1'b1, 3'b000, 32'h600, 32'h0, 5'd8,  32'h8001_7FFF, 2, 0);
    simple(1'b1, 3'b100, 32'h601, 32'h0, 5'd31, 32'h8001_7FFF, 0, 0);
    chk("lbu1_data", wb_data, 32'h0000_007F);
    simple(1'b0, 3'b000, 32'h701, 32'h1234_5678, 5'd0, 32'h0, 1, 0);
    simple(1'b0, 3'b010, 32'h704, 32'hCAFE_F00D, 5'd0, 32'h0, 0, 0);
    simple(1'b0, 3'b001, 32'h700, 32'h0000_A55A, 5'd0, 32'h0, 0, 0);

    // Rejections.
    reject_op(1'b1, 3'b010, 32'h302);
    reject_op(1'b1, 3'b011, 32'h300);
    reject_op(1'b1, 3'b001, 32'h301);
    reject_op(1'b0, 3'b100, 32'h300);

    // LW to rd 0: access happens, no writeback.
    simple(1'b1, 3'b010, 32'h400, 32'h0, 5'd0, 32'h1234_5678, 0, 0);
    chk("rd0_nowb", {31'd0, wb_v}, 32'd0);
    @(negedge clk);
    chk("rd0_nowb", {31'd0, wb_v}, 32'd0);
    chk("rd0_hold", wb_data, 32'h0000_007F);

    // Back-to-back: second LW held on x_valid from c0.
    @(negedge clk);
    issue(1'b1, 3'b010, 32'h800, 32'h0, 5'd3, 32'h1111_2222);
    @(negedge clk);
    x_addr = 32'h804; x_rd = 5'd4;
    serve(1'b1, 0, 0, 32'h1111_2222);
    chk("b2b_first", wb_data, 32'h1111_2222);
    issue(1'b1, 3'b010, 32'h804, 32'h0, 5'd4, 32'h3333_4444);
    @(negedge clk);
    x_valid = 1'b0;
    chk("b2b_accept_req",  {31'd0, dmem_req}, 32'd1);
    chk("b2b_accept_addr", dmem_addr, 32'h804);
    serve(1'b1, 1, 1, 32'h3333_4444);
    chk("b2b_second", wb_data, 32'h3333_4444);

    // Reset while in REQ: request drops asynchronously.
    @(negedge clk);
    issue(1'b0, 3'b010, 32'h900, 32'h1, 5'd0, 32'h0);
    @(negedge clk);
    x_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("rst_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rst_req_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in WAIT, late rvalid ignored.
    @(negedge clk);
    issue(1'b1, 3'b010, 32'h500, 32'h0, 5'd7, 32'hABCD_0123);
    @(negedge clk);
    x_valid = 1'b0;
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("wait_ready", {31'd0, ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1 chk("rst_wait_req",   {31'd0, dmem_req}, 32'd0);
    chk("rst_wait_ready", {31'd0, ready}, 32'd1);
    wb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hABCD_0123;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("late_rvalid_nowb",  {31'd0, wb_v}, 32'd0);
    chk("late_rvalid_noreq", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    chk("late_rvalid_nowb",  {31'd0, wb_v}, 32'd0);
    chk("late_rvalid_ready", {31'd0, ready}, 32'd1);

    repeat (2) @(negedge clk);
    chk("wb_all_seen", wb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
